// File: rtl/fp_hsv_to_rgb.sv
// Float32 HSV to float32 RGB (0..255) converter: fixed-point unpack, sector search by
// repeated subtraction, multi-cycle multiply sequence, then repack to float32.
module fp_hsv_to_rgb #(
  parameter int unsigned FRAC_W = 16,
  parameter int unsigned SCALE  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] H,
  input  logic [31:0] S,
  input  logic [31:0] V,
  input  logic        data_val_in,
  output logic [31:0] R,
  output logic [31:0] G,
  output logic [31:0] B,
  output logic        data_val_out,
  output logic        ready
);

  localparam int unsigned SV_W    = FRAC_W + 1;
  localparam int unsigned H_W     = FRAC_W + 9;
  localparam int unsigned SC_W    = SV_W + 8;
  localparam int unsigned RECIP60 = (2 ** FRAC_W) / 60;

  localparam logic [7:0]      EXP_OFF  = 8'(127 + 23 - FRAC_W);
  localparam logic [7:0]      HUE_ELIM = 8'(127 + 9);
  localparam logic [7:0]      ONE_EXP  = 8'd127;
  localparam logic [7:0]      PACK_OFF = 8'(127 - FRAC_W);
  localparam logic [SV_W-1:0] ONE      = SV_W'(2 ** FRAC_W);
  localparam logic [H_W-1:0]  SIXTY    = H_W'(60 * (2 ** FRAC_W));

  typedef enum logic [3:0] {
    ST_IDLE, ST_UNPACK, ST_SECTOR, ST_FRAC, ST_MUL1,
    ST_MUL2, ST_COMB, ST_SCALE, ST_PACK
  } state_t;

  state_t state, state_d;

  logic [31:0]     h_raw, s_raw, v_raw;
  logic [H_W-1:0]  h_fix;
  logic [SV_W-1:0] s_fix, v_fix, f, vs, p, vsf, q, t;
  logic [SC_W-1:0] v_sc, p_sc, q_sc, t_sc;
  logic [2:0]      sector;

  // Hue: negatives, zero/denormals and anything >= 512 (incl. Inf/NaN) collapse to 0.
  function automatic logic [H_W-1:0] unpack_h(input logic [31:0] x);
    logic [7:0] e;
    e = x[30:23];
    if (x[31] || e == 8'd0 || e >= HUE_ELIM) return '0;
    if (e >= EXP_OFF) return H_W'({24'd0, 1'b1, x[22:0]} << (e - EXP_OFF));
    return H_W'({24'd0, 1'b1, x[22:0]} >> (EXP_OFF - e));
  endfunction

  // S/V: saturate at 1.0, NaN and negatives go to 0.
  function automatic logic [SV_W-1:0] unpack_sv(input logic [31:0] x);
    logic [7:0] e;
    e = x[30:23];
    if (x[31] || e == 8'd0) return '0;
    if (e == 8'hFF && x[22:0] != 23'd0) return '0;
    if (e >= ONE_EXP) return ONE;
    return SV_W'({24'd0, 1'b1, x[22:0]} >> (EXP_OFF - e));
  endfunction

  function automatic logic [SC_W-1:0] scale(input logic [SV_W-1:0] x);
    return SC_W'(x) * SC_W'(SCALE);
  endfunction

  // Exact float32 repack of an unsigned Q8.FRAC_W value.
  function automatic logic [31:0] pack(input logic [SC_W-1:0] x);
    logic [7:0] msb;
    msb = '0;
    for (int i = 0; i < int'(SC_W); i++) if (x[i]) msb = 8'(i);
    if (x == '0) return '0;
    return {1'b0, PACK_OFF + msb, 23'({x, 23'd0} >> msb)};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (data_val_in) state_d = ST_UNPACK;
      ST_UNPACK: state_d = ST_SECTOR;
      ST_SECTOR: if (h_fix < SIXTY) state_d = ST_FRAC;
      ST_FRAC:   state_d = ST_MUL1;
      ST_MUL1:   state_d = ST_MUL2;
      ST_MUL2:   state_d = ST_COMB;
      ST_COMB:   state_d = ST_SCALE;
      ST_SCALE:  state_d = ST_PACK;
      ST_PACK:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath: each state updates only its own stage registers.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: if (data_val_in) begin
        h_raw <= H;
        s_raw <= S;
        v_raw <= V;
      end
      ST_UNPACK: begin
        h_fix  <= unpack_h(h_raw);
        s_fix  <= unpack_sv(s_raw);
        v_fix  <= unpack_sv(v_raw);
        sector <= 3'd0;
      end
      ST_SECTOR: if (h_fix >= SIXTY) begin
        h_fix  <= h_fix - SIXTY;
        sector <= (sector == 3'd5) ? 3'd0 : 3'(sector + 3'd1);
      end
      ST_FRAC: f  <= SV_W'(((H_W + FRAC_W)'(h_fix) * (H_W + FRAC_W)'(RECIP60)) >> FRAC_W);
      ST_MUL1: vs <= SV_W'(((2 * SV_W)'(v_fix) * (2 * SV_W)'(s_fix)) >> FRAC_W);
      ST_MUL2: begin
        p   <= v_fix - vs;
        vsf <= SV_W'(((2 * SV_W)'(vs) * (2 * SV_W)'(f)) >> FRAC_W);
      end
      ST_COMB: begin
        q <= v_fix - vsf;
        t <= p + vsf;
      end
      ST_SCALE: begin
        v_sc <= scale(v_fix);
        p_sc <= scale(p);
        q_sc <= scale(q);
        t_sc <= scale(t);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      R            <= '0;
      G            <= '0;
      B            <= '0;
      data_val_out <= 1'b0;
      ready        <= 1'b1;
    end else begin
      data_val_out <= (state == ST_PACK);
      ready        <= (state_d == ST_IDLE);
      if (state == ST_PACK) begin
        case (sector)
          3'd1:    begin R <= pack(q_sc); G <= pack(v_sc); B <= pack(p_sc); end
          3'd2:    begin R <= pack(p_sc); G <= pack(v_sc); B <= pack(t_sc); end
          3'd3:    begin R <= pack(p_sc); G <= pack(q_sc); B <= pack(v_sc); end
          3'd4:    begin R <= pack(t_sc); G <= pack(p_sc); B <= pack(v_sc); end
          3'd5:    begin R <= pack(v_sc); G <= pack(p_sc); B <= pack(q_sc); end
          default: begin R <= pack(v_sc); G <= pack(t_sc); B <= pack(p_sc); end
        endcase
      end
    end
  end

endmodule

// File: doc/fp_hsv_to_rgb.md
Name: fp_hsv_to_rgb

Overview:
- Inverse of the floating-point RGB-to-HSV converter. Takes one IEEE-754 single-precision H, S, V triple and returns single-precision R, G, B in the range 0.0 to 255.0.
- Sits on the same data_val_in/data_val_out stream so that RGB-to-HSV-to-RGB loopback runs can check the round trip.
- Internally: unpacks to unsigned fixed point, finds the sector by iterative subtraction, runs a multi-cycle multiply FSM, then repacks the results to float.

Parameters:
- FRAC_W, 16, fractional bits of the internal fixed-point format (S and V are Q1.FRAC_W; H is Q9.FRAC_W).
- SCALE, 255, integer full-scale multiplier applied to R, G, B before repacking.

Ports:
- clk  input  1  single clock; rising edge.
- rst  input  1  synchronous, active-high reset.
- H  input  32  hue in degrees, float32.
- S  input  32  saturation in 0..1, float32.
- V  input  32  value in 0..1, float32.
- data_val_in  input  1  input triple valid; sampled only while ready=1.
- R  output  32  red, float32.
- G  output  32  green, float32.
- B  output  32  blue, float32.
- data_val_out  output  1  one-cycle pulse; R, G, B are valid.
- ready  output  1  high when idle and able to accept a triple.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; R=G=B=32'h0; data_val_out=0; ready=1. Reset mid-conversion aborts it with no data_val_out pulse.
- States: IDLE -> UNPACK -> SECTOR -> FRAC -> MUL1 -> MUL2 -> COMB -> SCALE -> PACK -> IDLE.
- IDLE: when data_val_in=1, register H, S, V, drop ready, go to UNPACK. data_val_in while ready=0 is ignored (no queueing).
- UNPACK: float to fixed conversion, truncating bits below 2^-FRAC_W.
  - Sign=1, exponent=0 (zero or denormal) -> 0.
  - S or V >= 1.0 -> 1.0 (0x10000).
  - H >= 512, Inf or NaN -> 0.
  - S or V NaN -> 0.
- SECTOR: one cycle per test.
  - If h >= 60.0: h -= 60.0 and sector += 1, with sector wrapping 5 -> 0 so that 360..511 deg wraps.
  - Else go to FRAC.
  - Occupies k+1 cycles, where k = number of subtractions (0..8).
- FRAC: f = (h * 1092) >> 16, in Q0.16.
- MUL1: vs = (V*S) >> 16.
- MUL2: p = V - vs; vsf = (vs*f) >> 16.
- COMB: q = V - vsf; t = p + vsf. All values are 17-bit unsigned and never negative.
- SCALE: x*255 computed as (x<<8) - x, giving a 25-bit unsigned Q8.16 value.
- PACK: select by sector, then normalize each value to float32 via leading-zero count.
  - Sector 0..5 -> (R,G,B) = (V,t,p), (q,V,p), (p,V,t), (p,q,V), (t,p,V), (V,p,q).
  - Normalization: sign=0, exp = 127 + msb_index - 16, mantissa = bits below the msb, left-aligned. The conversion is exact because there are at most 24 significant bits.
  - A zero value packs to 32'h0.
  - R, G, B are registered and data_val_out=1 for exactly one cycle; state returns to IDLE and ready=1 in the same cycle.
- Latency: data_val_out asserts k+8 cycles after the accepting edge. Back-to-back: a new triple can be accepted in the cycle where data_val_out=1.
- R, G, B hold their last value until the next PACK or reset.

Test Plan:
- Reset then H=0, S=0, V=1.0 (32'h3F800000) -> R=G=B=32'h437F0000, data_val_out after 8 cycles.
- H=120.0 (32'h42F00000), S=1.0, V=1.0 -> R=0, G=32'h437F0000, B=0; k=2, data_val_out after 10 cycles.
- H=30.0 (32'h41F00000), S=1.0, V=1.0 -> R=32'h437F0000, G=32'h42FEF010, B=0.
- Boundaries:
  - H=420.0 (32'h43D20000), S=1.0, V=1.0 -> same as H=60: R=G=32'h437F0000, B=0, k=7.
  - V=-1.0 (32'hBF800000) -> all outputs 0.
  - S=2.0 -> result identical to S=1.0.
- Pulse data_val_in again mid-conversion -> it is ignored, exactly one data_val_out. Assert rst mid-conversion -> no pulse, outputs 0, ready=1 on the next cycle.
